// File: rtl/wb_ppfifo_2_mem_ring.sv
// wb_ppfifo_2_mem_ring: Wishbone-master DMA draining ppfifo blocks into NUM_BUFS round-robin memory buffers
// Ports: descriptor load (i_desc_*), per-buffer finished/clear (o_buf_finished/i_buf_clear),
// flush, status readback (i_stat_sel/o_stat_count), interrupt, Wishbone master (o_mem_*/i_mem_ack)
// and ppfifo read side (i_ppfifo_*/o_ppfifo_*).
module wb_ppfifo_2_mem_ring #(
  parameter int NUM_BUFS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_SIZE_W = 24,
  localparam int IDX_W = NUM_BUFS > 1 ? $clog2(NUM_BUFS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic                   i_desc_wr,
  input  logic [IDX_W-1:0]       i_desc_sel,
  input  logic [ADDR_WIDTH-1:0]  i_desc_base,
  input  logic [ADDR_WIDTH-1:0]  i_desc_size,
  input  logic [NUM_BUFS-1:0]    i_buf_clear,
  output logic [NUM_BUFS-1:0]    o_buf_finished,
  output logic [IDX_W-1:0]       o_active_buf,
  input  logic [IDX_W-1:0]       i_stat_sel,
  output logic [ADDR_WIDTH-1:0]  o_stat_count,
  output logic                   o_int,
  output logic                   o_mem_cyc,
  output logic                   o_mem_stb,
  output logic                   o_mem_we,
  output logic [3:0]             o_mem_sel,
  output logic [ADDR_WIDTH-1:0]  o_mem_adr,
  output logic [31:0]            o_mem_dat,
  input  logic                   i_mem_ack,
  input  logic                   i_ppfifo_rdy,
  output logic                   o_ppfifo_act,
  input  logic [FIFO_SIZE_W-1:0] i_ppfifo_size,
  output logic                   o_ppfifo_stb,
  input  logic [31:0]            i_ppfifo_data
);
  localparam logic [IDX_W:0] NB = (IDX_W+1)'(NUM_BUFS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BUFS - 1);
  typedef enum logic [1:0] {IDLE, GET_BLK, WRITE, CHECK} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q [NUM_BUFS];
  logic [ADDR_WIDTH-1:0] size_q [NUM_BUFS];
  logic [ADDR_WIDTH-1:0] count_q [NUM_BUFS];
  logic [NUM_BUFS-1:0] ready_q, fin_q, fin_d;
  logic [IDX_W-1:0] active_q, nxt;
  logic act_q, pend_q;
  logic [FIFO_SIZE_W-1:0] blk_size_q, blk_cnt_q;
  logic waiting, flush_ok, close, blk_done, nxt_ready, take_blk, pop, desc_ok, stb;
  assign nxt = active_q == LAST ? '0 : active_q + 1'b1;
  assign waiting = state_q == IDLE || state_q == GET_BLK;
  assign flush_ok = waiting && i_flush && ready_q[active_q] && count_q[active_q] != '0;
  // A flush seen during WRITE is held in pend_q and honoured at CHECK.
  assign close = flush_ok || (state_q == CHECK &&
                 (count_q[active_q] == size_q[active_q] || pend_q || i_flush));
  assign blk_done = blk_cnt_q == blk_size_q;
  // With a single slot the next buffer is the one being closed, so it is never ready.
  assign nxt_ready = ready_q[nxt] && nxt != active_q;
  assign take_blk = state_q == GET_BLK && !flush_ok && i_enable && !act_q && i_ppfifo_rdy;
  assign pop = state_q == WRITE && i_mem_ack;
  assign desc_ok = i_desc_wr && {1'b0, i_desc_sel} < NB &&
                   !(i_desc_sel == active_q && ready_q[active_q]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !flush_ok && i_enable && ready_q[active_q] ? GET_BLK : IDLE;
      GET_BLK: state_d = flush_ok || !i_enable ? IDLE : act_q || i_ppfifo_rdy ? WRITE : GET_BLK;
      WRITE:   state_d = i_mem_ack ? CHECK : WRITE;
      default: state_d = !i_enable || (close && !nxt_ready) ? IDLE : blk_done ? GET_BLK : WRITE;
    endcase
  end
  always_comb begin
    fin_d = fin_q & ~i_buf_clear;
    if (desc_ok) fin_d[i_desc_sel] = 1'b0;
    if (close) fin_d[active_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= '0;
      fin_q <= '0;
      active_q <= '0;
      act_q <= 1'b0;
      pend_q <= 1'b0;
      blk_size_q <= '0;
      blk_cnt_q <= '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fin_q <= fin_d;
      pend_q <= state_q == WRITE && (pend_q || i_flush);
      if (desc_ok) begin
        base_q[i_desc_sel] <= i_desc_base;
        size_q[i_desc_sel] <= i_desc_size;
        count_q[i_desc_sel] <= '0;
        ready_q[i_desc_sel] <= i_desc_size != '0;
      end
      if (pop) begin
        count_q[active_q] <= count_q[active_q] + 1'b1;
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
      if (close) begin
        ready_q[active_q] <= 1'b0;
        active_q <= nxt;
      end
      if (take_blk) begin
        act_q <= 1'b1;
        blk_size_q <= i_ppfifo_size;
        blk_cnt_q <= '0;
      end else if (state_q == CHECK && blk_done) act_q <= 1'b0;
    end
  end
  // Bus strobes and the FIFO claim are masked by rst so they fall in the reset cycle itself.
  assign stb = !rst && state_q == WRITE;
  assign o_mem_stb = stb;
  assign o_mem_we = stb;
  assign o_mem_cyc = stb || (!rst && state_q == CHECK && state_d == WRITE);
  assign o_mem_sel = {4{stb}};
  assign o_mem_adr = stb ? base_q[active_q] + count_q[active_q] : '0;
  assign o_mem_dat = stb ? i_ppfifo_data : '0;
  assign o_ppfifo_act = !rst && act_q;
  assign o_ppfifo_stb = !rst && pop;
  assign o_buf_finished = fin_q;
  assign o_active_buf = active_q;
  assign o_int = |fin_q && i_enable;
  assign o_stat_count = {1'b0, i_stat_sel} < NB ? count_q[i_stat_sel] : '0;
endmodule

// File: tb/tb_wb_ppfifo_2_mem_ring.sv
// tb_wb_ppfifo_2_mem_ring: directed bench with FIFO source and Wishbone slave models
module tb_wb_ppfifo_2_mem_ring;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0, desc_wr = 1'b0;
  logic [0:0] desc_sel = '0, stat_sel = '0, active;
  logic [31:0] desc_base = '0, desc_size = '0, stat_count, adr, dat, fdata;
  logic [1:0] buf_clear = '0, fin;
  logic int_o, cyc, stb, we, ack, fifo_rdy, act, fstb, act_prev;
  logic [3:0] sel;
  logic [23:0] fsize = '0;
  int given = 0, taken = 0, dly = 0, wcnt = 0, rd = 0, errors = 0, checks = 0;
  logic [31:0] next_word = '0;
  logic [31:0] wa [$], wd [$];

  always #5 clk = ~clk;

  wb_ppfifo_2_mem_ring #(.NUM_BUFS(2), .ADDR_WIDTH(32), .FIFO_SIZE_W(24)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_flush(flush), .i_desc_wr(desc_wr),
    .i_desc_sel(desc_sel), .i_desc_base(desc_base), .i_desc_size(desc_size),
    .i_buf_clear(buf_clear), .o_buf_finished(fin), .o_active_buf(active),
    .i_stat_sel(stat_sel), .o_stat_count(stat_count), .o_int(int_o),
    .o_mem_cyc(cyc), .o_mem_stb(stb), .o_mem_we(we), .o_mem_sel(sel),
    .o_mem_adr(adr), .o_mem_dat(dat), .i_mem_ack(ack),
    .i_ppfifo_rdy(fifo_rdy), .o_ppfifo_act(act), .i_ppfifo_size(fsize),
    .o_ppfifo_stb(fstb), .i_ppfifo_data(fdata)
  );

  assign fifo_rdy = given > taken && !act;
  assign fdata = next_word;

  always @(posedge clk) begin
    act_prev <= act;
    if (act && !act_prev) taken <= taken + 1;
    if (fstb) next_word <= next_word + 1;
    if (rst) begin
      ack <= 1'b0;
      wcnt <= 0;
    end else if (stb && !ack) begin
      if (wcnt >= dly) begin
        ack <= 1'b1;
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else ack <= 1'b0;
    if (stb && ack) begin
      wa.push_back(adr);
      wd.push_back(dat);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic desc(input int s, input logic [31:0] b, input logic [31:0] sz);
    @(negedge clk);
    desc_sel = 1'(s);
    desc_base = b;
    desc_size = sz;
    desc_wr = 1'b1;
    @(negedge clk);
    desc_wr = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wa.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("wr_count_reached", wa.size(), n);
  endtask

  task automatic wait_stb();
    int t = 0;
    while (!stb && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stb_seen", stb, 1);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    if (rd < wa.size()) begin
      check("wr_adr", wa[rd], a);
      check("wr_dat", wd[rd], d);
    end else check("wr_present", wa.size(), rd + 1);
    rd++;
  endtask

  task automatic clear(input logic [1:0] m);
    @(negedge clk);
    buf_clear = m;
    @(negedge clk);
    buf_clear = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_act", act, 0);
    check("rst_fin", fin, 0);
    check("rst_active", active, 0);
    check("rst_int", int_o, 0);
    check("rst_count", stat_count, 0);
    // two size-4 buffers filled from one 8-word block
    desc(0, 32'h100, 4);
    desc(1, 32'h200, 4);
    fsize = 8;
    given = 1;
    en = 1'b1;
    wait_wr(8);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_wr(32'h100 + i, i);
    for (int i = 0; i < 4; i++) exp_wr(32'h200 + i, 4 + i);
    check("t1_fin", fin, 2'b11);
    check("t1_int", int_o, 1);
    check("t1_act", act, 0);
    check("t1_cyc", cyc, 0);
    check("t1_active", active, 0);
    check("t1_count0", stat_count, 4);
    check("t1_total", wa.size(), 8);
    clear(2'b11);
    check("clr_fin", fin, 0);
    check("clr_int", int_o, 0);
    // buffer 0 fills mid-block while buffer 1 is not ready
    desc(0, 32'h300, 3);
    fsize = 5;
    given = 2;
    wait_wr(11);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_wr(32'h300 + i, 8 + i);
    check("t2_act_held", act, 1);
    check("t2_cyc", cyc, 0);
    check("t2_active", active, 1);
    check("t2_fin", fin, 2'b01);
    check("t2_total", wa.size(), 11);
    desc(1, 32'h400, 16);
    wait_wr(13);
    repeat (5) @(negedge clk);
    exp_wr(32'h400, 11);
    exp_wr(32'h401, 12);
    stat_sel = 1'b1;
    #1;
    check("t2_act_drop", act, 0);
    check("t2_count1", stat_count, 2);
    // flush the partially filled buffer 1
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fin", fin, 2'b11);
    check("flush_active", active, 0);
    check("flush_count1", stat_count, 2);
    check("flush_cyc", cyc, 0);
    clear(2'b11);
    // slow ack, enable dropped mid-WRITE
    dly = 5;
    fsize = 4;
    given = 3;
    desc(0, 32'h500, 4);
    wait_stb();
    en = 1'b0;
    wait_wr(14);
    repeat (10) @(negedge clk);
    stat_sel = 1'b0;
    #1;
    check("halt_total", wa.size(), 14);
    check("halt_cyc", cyc, 0);
    check("halt_stb", stb, 0);
    check("halt_act", act, 1);
    check("halt_count0", stat_count, 1);
    exp_wr(32'h500, 13);
    en = 1'b1;
    wait_wr(17);
    repeat (5) @(negedge clk);
    for (int i = 1; i < 4; i++) exp_wr(32'h500 + i, 13 + i);
    check("resume_fin", fin, 2'b01);
    check("resume_active", active, 1);
    check("resume_act", act, 0);
    clear(2'b01);
    // clear asserted in the same cycle the finished flag is set
    dly = 0;
    fsize = 2;
    given = 4;
    desc(1, 32'h600, 2);
    wait_wr(19);
    buf_clear = 2'b10;
    @(negedge clk);
    check("set_wins", fin, 2'b10);
    buf_clear = '0;
    exp_wr(32'h600, 17);
    exp_wr(32'h601, 18);
    check("set_active", active, 0);
    // reset in the middle of a WRITE
    dly = 5;
    fsize = 4;
    given = 5;
    desc(0, 32'h700, 4);
    wait_stb();
    rst = 1'b1;
    #1;
    check("rstw_cyc", cyc, 0);
    check("rstw_stb", stb, 0);
    check("rstw_act", act, 0);
    check("rstw_sel", sel, 0);
    @(negedge clk);
    check("rstw_fin", fin, 0);
    check("rstw_active", active, 0);
    check("rstw_count", stat_count, 0);
    check("rstw_int", int_o, 0);
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
